// File: rtl/joy_pkg.sv
// joy_pkg: types and constants shared by the MD pad scan sequencer.
//   - button bit indices and the 12-bit published button type
//   - pad line bundle (active-low, as seen on the DB9 pins)
//   - FSM state codes
//   - scan step numbers at which the decoder samples
package joy_pkg;

  localparam int BTN_W     = 12;
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_B1    = 4;
  localparam int BTN_B2    = 5;
  localparam int BTN_B3    = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  typedef logic [BTN_W-1:0] btn_t;

  // Shared pad lines, active-low.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic b1;
    logic b2;
  } pad_lines_t;

  // Scheduler states.
  typedef logic [1:0] joy_state_t;
  localparam joy_state_t ST_IDLE   = 2'd0;
  localparam joy_state_t ST_SETTLE = 2'd1;
  localparam joy_state_t ST_SCAN   = 2'd2;
  localparam joy_state_t ST_NEXT   = 2'd3;

  // Scan steps (select low on even steps).
  localparam logic [2:0] STEP_MD   = 3'd2;  // 3-button ID + A/Start
  localparam logic [2:0] STEP_DIR  = 3'd3;  // directions + B/C
  localparam logic [2:0] STEP_MD6  = 3'd4;  // 6-button ID
  localparam logic [2:0] STEP_XYZ  = 3'd5;  // X/Y/Z/Mode
  localparam logic [2:0] STEP_LAST = 3'd7;

endpackage

// File: rtl/joy_md_decoder.sv
// joy_md_decoder: shadow registers for one pad scan. Samples the shared pad
// lines at the strobed end of each scan step and builds the button vector
// and pad-type flags. Shared by both ports; cleared before each port.
//   clk28, rst  : clock, async active-high reset
//   clr         : discard shadow (held during the settle step)
//   stb         : last cycle of the current scan step
//   step        : scan step index 0..7
//   lines       : pad lines, active-low
//   btn/md/md6  : shadow outputs, active-high
module joy_md_decoder
  import joy_pkg::*;
(
  input  logic       clk28,
  input  logic       rst,
  input  logic       clr,
  input  logic       stb,
  input  logic [2:0] step,
  input  pad_lines_t lines,
  output btn_t       btn,
  output logic       md,
  output logic       md6
);

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      btn <= '0;
      md  <= 1'b0;
      md6 <= 1'b0;
    end else if (clr) begin
      btn <= '0;
      md  <= 1'b0;
      md6 <= 1'b0;
    end else if (stb) begin
      case (step)
        // An MD pad pulls left+right low while select is low.
        STEP_MD: begin
          if (!lines.left && !lines.right) begin
            md              <= 1'b1;
            btn[BTN_B3]     <= ~lines.b1;
            btn[BTN_START]  <= ~lines.b2;
          end else begin
            md              <= 1'b0;
            btn[BTN_B3]     <= 1'b0;
            btn[BTN_START]  <= 1'b0;
          end
        end
        STEP_DIR: begin
          btn[BTN_UP]    <= ~lines.up;
          btn[BTN_DOWN]  <= ~lines.down;
          btn[BTN_LEFT]  <= ~lines.left;
          btn[BTN_RIGHT] <= ~lines.right;
          btn[BTN_B1]    <= ~lines.b1;
          btn[BTN_B2]    <= ~lines.b2;
        end
        // Third low phase of a 6-button pad drives all directions low.
        STEP_MD6: md6 <= md & ~lines.up & ~lines.down;
        STEP_XYZ: begin
          btn[BTN_MODE] <= md6 & ~lines.right;
          btn[BTN_X]    <= md6 & ~lines.left;
          btn[BTN_Y]    <= md6 & ~lines.down;
          btn[BTN_Z]    <= md6 & ~lines.up;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/joy_scan_sched.sv
// joy_scan_sched: scan sequencer for MD 3/6-button pads on up to two DB9
// ports sharing one set of input lines through an external port buffer.
// Owns select toggling, port switching, settle gap, sample points and the
// automatic scan period; publishes per-port results atomically.
//
// Build option: JOY_PORT2_EN -- when defined, scans port 0 then port 1;
// otherwise only port 0 is scanned and all port-1 outputs are held at 0.
//
// Ports:
//   clk28, rst          : clock, async active-high reset
//   scan_req            : one-cycle request for an immediate scan
//   n_joy_*             : shared pad lines, active-low, synchronised
//   joy_sel, joy_port   : pad select line, external port select
//   busy                : scan sequence in progress
//   btn0/btn1           : published buttons (active-high)
//   md0/md1, md6_0/md6_1: MD / 6-button pad detected at last scan
//   upd[1:0]            : one-cycle pulse when a port is republished
module joy_scan_sched
  import joy_pkg::*;
#(
  parameter int STEP_CYCLES   = 128,
  parameter int PERIOD_CYCLES = 224000
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        scan_req,
  input  logic        n_joy_up,
  input  logic        n_joy_down,
  input  logic        n_joy_left,
  input  logic        n_joy_right,
  input  logic        n_joy_b1,
  input  logic        n_joy_b2,
  output logic        joy_sel,
  output logic        joy_port,
  output logic        busy,
  output logic [11:0] btn0,
  output logic [11:0] btn1,
  output logic        md0,
  output logic        md1,
  output logic        md6_0,
  output logic        md6_1,
  output logic [1:0]  upd
);

`ifdef JOY_PORT2_EN
  localparam int NPORTS = 2;
`else
  localparam int NPORTS = 1;
`endif
  localparam int SW = $clog2(STEP_CYCLES);
  localparam int PW = $clog2(PERIOD_CYCLES);

  joy_state_t   state;
  logic [SW-1:0] step_cnt;
  logic [2:0]   step;
  logic         port;
  logic         pending;
  logic [PW-1:0] per_cnt;
  logic         tick;
  logic         step_end;
  logic         publish;

  pad_lines_t   lines;
  btn_t         dec_btn;
  logic         dec_md, dec_md6;

  // Scan period: independent of the video counters.
  assign tick = (per_cnt == PW'(PERIOD_CYCLES - 1));

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) per_cnt <= '0;
    else     per_cnt <= tick ? '0 : per_cnt + 1'b1;
  end

  // Requests collapse into a single pending scan; IDLE consumes it.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) pending <= 1'b0;
    else     pending <= (pending & (state != ST_IDLE)) | tick | scan_req;
  end

  assign step_end = (step_cnt == SW'(STEP_CYCLES - 1));
  assign publish  = (state == ST_SCAN) && step_end && (step == STEP_LAST);

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      step     <= '0;
      port     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) begin
            state    <= ST_SETTLE;
            step_cnt <= '0;
            port     <= 1'b0;
          end
        end
        ST_SETTLE: begin
          step_cnt <= step_cnt + 1'b1;
          if (step_end) begin
            state    <= ST_SCAN;
            step_cnt <= '0;
            step     <= '0;
          end
        end
        ST_SCAN: begin
          step_cnt <= step_cnt + 1'b1;
          if (step_end) begin
            step_cnt <= '0;
            if (step == STEP_LAST) state <= ST_NEXT;
            else                   step  <= step + 1'b1;
          end
        end
        default: begin  // ST_NEXT
          step_cnt <= '0;
          // Port only moves while select is high (settle step follows).
          if (!port && NPORTS > 1) begin
            state <= ST_SETTLE;
            port  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            port  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign joy_sel = (state == ST_SCAN) ? step[0] : 1'b1;

  assign lines = {n_joy_up, n_joy_down, n_joy_left, n_joy_right, n_joy_b1, n_joy_b2};

  joy_md_decoder u_dec (
    .clk28 (clk28),
    .rst   (rst),
    .clr   (state == ST_SETTLE),
    .stb   ((state == ST_SCAN) && step_end),
    .step  (step),
    .lines (lines),
    .btn   (dec_btn),
    .md    (dec_md),
    .md6   (dec_md6)
  );

  // Published registers, one set per port; written whole from the shadow.
  btn_t [NPORTS-1:0] pub_btn;
  logic [NPORTS-1:0] pub_md, pub_md6, pub_upd;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic hit;
    assign hit = publish && (int'(port) == p);

    always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
        pub_btn[p] <= '0;
        pub_md[p]  <= 1'b0;
        pub_md6[p] <= 1'b0;
        pub_upd[p] <= 1'b0;
      end else begin
        pub_upd[p] <= hit;
        if (hit) begin
          pub_btn[p] <= dec_btn;
          pub_md[p]  <= dec_md;
          pub_md6[p] <= dec_md6;
        end
      end
    end
  end

  assign btn0   = pub_btn[0];
  assign md0    = pub_md[0];
  assign md6_0  = pub_md6[0];
  assign upd[0] = pub_upd[0];
`ifdef JOY_PORT2_EN
  assign btn1     = pub_btn[1];
  assign md1      = pub_md[1];
  assign md6_1    = pub_md6[1];
  assign upd[1]   = pub_upd[1];
  assign joy_port = port;
`else
  assign btn1     = '0;
  assign md1      = 1'b0;
  assign md6_1    = 1'b0;
  assign upd[1]   = 1'b0;
  assign joy_port = 1'b0;
`endif

endmodule

// File: tb/tb_joy_scan_sched.sv
// Bench for joy_scan_sched: pad models on both ports, table of pad setups
// with hand-computed results, plus sequences for request collapsing,
// mid-scan reset and port/select timing.
module tb_joy_scan_sched;

  localparam int STEP = 128;
  localparam int PER  = 10000;
`ifdef JOY_PORT2_EN
  localparam bit TWO = 1'b1;
`else
  localparam bit TWO = 1'b0;
`endif

  logic        clk28 = 1'b0;
  logic        rst = 1'b1;
  logic        scan_req = 1'b0;
  logic        n_joy_up, n_joy_down, n_joy_left, n_joy_right, n_joy_b1, n_joy_b2;
  logic        joy_sel, joy_port, busy;
  logic [11:0] btn0, btn1;
  logic        md0, md1, md6_0, md6_1;
  logic [1:0]  upd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk28 = ~clk28;

  joy_scan_sched #(.STEP_CYCLES(STEP), .PERIOD_CYCLES(PER)) dut (
    .clk28(clk28), .rst(rst), .scan_req(scan_req),
    .n_joy_up(n_joy_up), .n_joy_down(n_joy_down), .n_joy_left(n_joy_left),
    .n_joy_right(n_joy_right), .n_joy_b1(n_joy_b1), .n_joy_b2(n_joy_b2),
    .joy_sel(joy_sel), .joy_port(joy_port), .busy(busy),
    .btn0(btn0), .btn1(btn1), .md0(md0), .md1(md1),
    .md6_0(md6_0), .md6_1(md6_1), .upd(upd)
  );

  // ---------------- pad models ----------------
  // type: 0 none, 1 three-button, 2 six-button; buttons in output bit order
  logic [1:0]  pt0 = 2'd0, pt1 = 2'd0;
  logic [11:0] pb0 = '0, pb1 = '0;
  int          lc0 = 0, lc1 = 0;   // select low phases seen by each pad
  logic        sel_q = 1'b1;

  always @(posedge clk28) begin
    sel_q <= joy_sel;
    if (rst || !busy) begin
      lc0 <= 0;
      lc1 <= 0;
    end else if (sel_q && !joy_sel) begin
      if (joy_port) lc1 <= lc1 + 1;
      else          lc0 <= lc0 + 1;
    end
  end

  // returns active-low {up,down,left,right,b1,b2}
  function automatic logic [5:0] pad_out(input logic [1:0] t, input logic [11:0] b,
                                         input logic sel, input int lc);
    logic u, d, l, r, p1, p2;
    if (t == 2'd0) return 6'h3f;
    if (sel) begin
      if (t == 2'd2 && lc == 3) {u, d, l, r} = {b[11], b[10], b[9], b[8]};
      else                      {u, d, l, r} = {b[3], b[2], b[1], b[0]};
      p1 = b[4];
      p2 = b[5];
    end else begin
      if (t == 2'd2 && lc == 3)      {u, d, l, r} = 4'hf;
      else if (t == 2'd2 && lc >= 4) {u, d, l, r} = 4'h0;
      else                           {u, d, l, r} = {b[3], b[2], 1'b1, 1'b1};
      p1 = b[6];
      p2 = b[7];
    end
    return ~{u, d, l, r, p1, p2};
  endfunction

  always_comb begin
    {n_joy_up, n_joy_down, n_joy_left, n_joy_right, n_joy_b1, n_joy_b2} =
      joy_port ? pad_out(pt1, pb1, joy_sel, lc1) : pad_out(pt0, pb0, joy_sel, lc0);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk28);
    rst = 1'b0;
  endtask

  // One scan from scan_req; cycle times are relative to the first busy cycle.
  task automatic scan_once(output int t_u0, output int t_u1, output int n_u,
                           output int t_busy, output int settle0, output int settle1,
                           output int n_chg, output int viol);
    int n, c, chg_at;
    logic prev_port, prev_sel;
    t_u0 = -1; t_u1 = -1; n_u = 0; settle0 = -1; settle1 = -1;
    n_chg = 0; viol = 0; chg_at = -1;
    scan_req = 1'b1;
    @(negedge clk28);
    scan_req = 1'b0;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk28);
      n++;
    end
    chk("busy_start", busy, 1);
    c = 0;
    prev_port = joy_port;
    prev_sel  = joy_sel;
    while (busy && c < 5000) begin
      if (upd[0]) begin t_u0 = c; n_u++; end
      if (upd[1]) begin t_u1 = c; n_u++; end
      if (joy_port != prev_port) begin
        n_chg++;
        chg_at = c;
        if (!joy_sel || !prev_sel) viol++;
      end
      if (prev_sel && !joy_sel) begin
        if (settle0 < 0) settle0 = c;
        if (chg_at >= 0 && settle1 < 0) settle1 = c - chg_at;
      end
      prev_port = joy_port;
      prev_sel  = joy_sel;
      @(negedge clk28);
      c++;
    end
    t_busy = c;
  endtask

  typedef struct {
    logic [1:0]  t0;
    logic [11:0] b0;
    logic [1:0]  t1;
    logic [11:0] b1;
    logic [11:0] e_btn0;
    logic        e_md0;
    logic        e_md60;
    logic [11:0] e_btn1;
    logic        e_md1;
    logic        e_md61;
  } vec_t;

  vec_t vt [5];

  initial begin
    int tu0, tu1, nu, tb, s0, s1, nc, vi;
    int rises, pulses, c;
    logic bq;

    vt[0] = '{2'd1, 12'h040, 2'd0, 12'h000, 12'h040, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0};
    vt[1] = '{2'd2, 12'h091, 2'd2, 12'h808, 12'h091, 1'b1, 1'b1, 12'h808, 1'b1, 1'b1};
    vt[2] = '{2'd0, 12'h000, 2'd1, 12'h0e5, 12'h000, 1'b0, 1'b0, 12'h0e5, 1'b1, 1'b0};
    vt[3] = '{2'd2, 12'hfff, 2'd0, 12'h000, 12'hfff, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};
    vt[4] = '{2'd2, 12'h502, 2'd1, 12'h010, 12'h502, 1'b1, 1'b1, 12'h010, 1'b1, 1'b0};

    // ---- table: one full scan per pad setup ----
    for (int i = 0; i < 5; i++) begin
      do_reset();
      pt0 = vt[i].t0; pb0 = vt[i].b0; pt1 = vt[i].t1; pb1 = vt[i].b1;
      @(negedge clk28);
      chk("rst_flags", {busy, joy_sel, joy_port, upd, md0, md6_0, md1, md6_1}, 9'b010000000);
      chk("rst_btn", {btn1, btn0}, 0);
      scan_once(tu0, tu1, nu, tb, s0, s1, nc, vi);
      chk("btn0", btn0, vt[i].e_btn0);
      chk("md0", md0, vt[i].e_md0);
      chk("md6_0", md6_0, vt[i].e_md60);
      chk("btn1", btn1, TWO ? vt[i].e_btn1 : 12'h000);
      chk("md1", md1, TWO ? vt[i].e_md1 : 1'b0);
      chk("md6_1", md6_1, TWO ? vt[i].e_md61 : 1'b0);
      chk("upd0_time", tu0, 1152);
      chk("upd1_time", tu1, TWO ? 2305 : -1);
      chk("upd_count", nu, TWO ? 2 : 1);
      chk("busy_len", tb, TWO ? 2306 : 1153);
      chk("settle0", s0, STEP);
      chk("settle1", s1, TWO ? STEP : -1);
      chk("port_changes", nc, TWO ? 1 : 0);
      chk("port_while_sel_low", vi, 0);
      chk("port_idle", joy_port, 0);
    end

    // ---- tick and scan_req together, then three requests while busy ----
    do_reset();
    pt0 = 2'd1; pb0 = 12'h040; pt1 = 2'd2; pb1 = 12'h808;
    repeat (PER - 1) @(negedge clk28);
    scan_req = 1'b1;
    @(negedge clk28);
    scan_req = 1'b0;
    rises = 0; pulses = 0; bq = busy;
    for (c = 0; c < 5100; c++) begin
      scan_req = (c == 100 || c == 300 || c == 500);
      if (busy && !bq) rises++;
      pulses += int'(upd[0]) + int'(upd[1]);
      bq = busy;
      @(negedge clk28);
    end
    scan_req = 1'b0;
    chk("collapse_scans", rises, 2);
    chk("collapse_upd", pulses, TWO ? 4 : 2);
    chk("collapse_idle", busy, 0);

    // ---- reset during scan step 4 ----
    do_reset();
    pt0 = 2'd2; pb0 = 12'hfff; pt1 = 2'd1; pb1 = 12'h0e5;
    scan_once(tu0, tu1, nu, tb, s0, s1, nc, vi);
    chk("pre_btn0", btn0, 12'hfff);
    scan_req = 1'b1;
    @(negedge clk28);
    scan_req = 1'b0;
    c = 0;
    while (!busy && c < 20) begin
      @(negedge clk28);
      c++;
    end
    repeat (700) @(negedge clk28);
    chk("sel_step4", {busy, joy_sel}, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("midrst_btn", {btn1, btn0}, 0);
    chk("midrst_flags", {busy, joy_sel, joy_port, upd, md0, md6_0, md1, md6_1}, 9'b010000000);
    @(negedge clk28);
    @(negedge clk28);
    rst = 1'b0;
    @(negedge clk28);
    scan_once(tu0, tu1, nu, tb, s0, s1, nc, vi);
    chk("post_btn0", btn0, 12'hfff);
    chk("post_md6_0", md6_0, 1);
    chk("post_btn1", btn1, TWO ? 12'h0e5 : 12'h000);
    chk("post_upd0_time", tu0, 1152);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
